maze_path_checker: RTL and testbench

// - Downstream consumer of the maze solver's move stream (valid + 2-bit direction per cycle).
// - Replays moves from START cell, tracks position, flags illegal moves.
// - Reports one pass/fail verdict with step count per stream; acts as on-chip self-check of solver output.

---
 rtl/maze_pkg.sv | 29 ++
 rtl/maze_rle_packer.sv | 72 +++++++
 rtl/maze_path_checker.sv | 150 +++++++++++++++
 tb/tb_maze_path_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maze_pkg
// Purpose  : Shared types and constants for the maze path checker: move
//            direction encoding, maze geometry defaults and the helper that
//            maps a direction to its exact opposite.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int MAZE_DIM  = 17;  // last interior row/col index
  localparam int START_POS = 1;   // start row and start col
  localparam int GOAL_POS  = 17;  // goal row and goal col

  typedef enum logic [1:0] {
    DIR_E = 2'd0,  // +col
    DIR_S = 2'd1,  // +row
    DIR_W = 2'd2,  // -col
    DIR_N = 2'd3   // -row
  } dir_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maze_rle_packer.sv
`default_nettype none
// ============================================================================
// Module   : maze_rle_packer
// Purpose  : Run-length packer for the accepted move stream. Emits one
//            (dir, len) record whenever the direction changes, when a run
//            reaches MAX_RUN, and for the final run at end of stream.
// Ports    : clk, rst_n      - clock, async active-low reset
//            move_valid      - a move is accepted this cycle
//            move_first      - the accepted move opens a new stream
//            move_dir        - direction of the accepted move
//            stream_end      - stream closed this cycle (no move)
//            rle_valid       - 1-cycle record strobe
//            rle_dir/rle_len - record contents, held between strobes
// Revision : 1.0 - initial release
// ============================================================================
module maze_rle_packer #(
  parameter int MAX_RUN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_valid,
  input  logic       move_first,
  input  logic [1:0] move_dir,
  input  logic       stream_end,
  output logic       rle_valid,
  output logic [1:0] rle_dir,
  output logic [4:0] rle_len
);
  import maze_pkg::*;

  localparam logic [4:0] C_MAX_RUN = 5'(MAX_RUN);

  dir_t       run_dir;
  logic [4:0] run_len;
  dir_t       dir_in;

  assign dir_in = dir_t'(move_dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_dir   <= DIR_E;
      run_len   <= 5'd0;
      rle_valid <= 1'b0;
      rle_dir   <= 2'd0;
      rle_len   <= 5'd0;
    end else begin
      rle_valid <= 1'b0;
      if (move_valid) begin
        if (move_first) begin
          run_dir <= dir_in;
          run_len <= 5'd1;
        end else if (dir_in != run_dir || run_len == C_MAX_RUN) begin
          // Close the current run; a full-length run is split so that the
          // reported length never leaves 1..MAX_RUN.
          rle_valid <= 1'b1;
          rle_dir   <= run_dir;
          rle_len   <= run_len;
          run_dir   <= dir_in;
          run_len   <= 5'd1;
        end else begin
          run_len <= run_len + 5'd1;
        end
      end else if (stream_end) begin
        rle_valid <= 1'b1;
        rle_dir   <= run_dir;
        rle_len   <= run_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maze_path_checker.sv
`default_nettype none
// ============================================================================
// Module   : maze_path_checker
// Purpose  : Replays the maze solver's move stream from the start cell,
//            tracks position, flags illegal moves and reports one pass/fail
//            verdict with step count per stream.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid, in_dir      - move stream (0=E 1=S 2=W 3=N)
//            pos_row, pos_col      - current position
//            step_count            - accepted moves, saturating
//            err_bounds/reverse/overrun - sticky error flags
//            done_valid, done_ok   - 1-cycle verdict strobe and verdict
//            rle_valid/dir/len     - run-length records (PATH_RLE_EN only)
// Config   : `define PATH_RLE_EN adds the run-length record outputs.
// Revision : 1.0 - initial release
// ============================================================================
module maze_path_checker #(
  parameter int MAZE_DIM  = 17,
  parameter int START_POS = 1,
  parameter int GOAL_POS  = 17,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       in_dir,
  output logic [4:0]       pos_row,
  output logic [4:0]       pos_col,
  output logic [CNT_W-1:0] step_count,
  output logic             err_bounds,
  output logic             err_reverse,
  output logic             err_overrun,
  output logic             done_valid,
  output logic             done_ok
`ifdef PATH_RLE_EN
  ,
  output logic             rle_valid,
  output logic [1:0]       rle_dir,
  output logic [4:0]       rle_len
`endif
);
  import maze_pkg::*;

  localparam logic [4:0]       C_DIM   = 5'(MAZE_DIM);
  localparam logic [4:0]       C_START = 5'(START_POS);
  localparam logic [4:0]       C_GOAL  = 5'(GOAL_POS);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t           state;
  dir_t             prev_dir;
  dir_t             dir;
  logic             start;
  logic             stream_end;
  logic [4:0]       base_row, base_col;
  logic [4:0]       nxt_row, nxt_col;
  logic             mv_bounds, mv_reverse, mv_overrun;
  logic [CNT_W-1:0] nxt_cnt;

  // Evaluate the incoming move against the position it applies to. A stream
  // start (from IDLE or REPORT) applies to the start cell with cleared history.
  always_comb begin
    dir        = dir_t'(in_dir);
    start      = in_valid && (state != ST_TRACK);
    stream_end = (state == ST_TRACK) && !in_valid;
    base_row   = start ? C_START : pos_row;
    base_col   = start ? C_START : pos_col;
    mv_overrun = (base_row == C_GOAL) && (base_col == C_GOAL);
    mv_reverse = !start && (dir == opposite_dir(prev_dir));
    nxt_row    = base_row;
    nxt_col    = base_col;
    mv_bounds  = 1'b0;
    // Bounds are tested before arithmetic so an illegal move never wraps.
    case (dir)
      DIR_E: if (base_col >= C_DIM) mv_bounds = 1'b1; else nxt_col = base_col + 5'd1;
      DIR_S: if (base_row >= C_DIM) mv_bounds = 1'b1; else nxt_row = base_row + 5'd1;
      DIR_W: if (base_col <= 5'd1)  mv_bounds = 1'b1; else nxt_col = base_col - 5'd1;
      DIR_N: if (base_row <= 5'd1)  mv_bounds = 1'b1; else nxt_row = base_row - 5'd1;
      default: mv_bounds = 1'b0;
    endcase
    if (start)
      nxt_cnt = CNT_W'(1);
    else if (step_count == C_CNT_MAX)
      nxt_cnt = step_count;
    else
      nxt_cnt = step_count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      prev_dir    <= DIR_E;
      pos_row     <= C_START;
      pos_col     <= C_START;
      step_count  <= '0;
      err_bounds  <= 1'b0;
      err_reverse <= 1'b0;
      err_overrun <= 1'b0;
      done_valid  <= 1'b0;
      done_ok     <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      if (in_valid) begin
        // Any valid cycle accepts a move; outside TRACK it also opens a stream.
        state       <= ST_TRACK;
        prev_dir    <= dir;
        pos_row     <= nxt_row;
        pos_col     <= nxt_col;
        step_count  <= nxt_cnt;
        err_bounds  <= (err_bounds  && !start) || mv_bounds;
        err_reverse <= (err_reverse && !start) || mv_reverse;
        err_overrun <= (err_overrun && !start) || mv_overrun;
      end else if (state == ST_TRACK) begin
        state      <= ST_REPORT;
        done_valid <= 1'b1;
        done_ok    <= (pos_row == C_GOAL) && (pos_col == C_GOAL) &&
                      !err_bounds && !err_reverse && !err_overrun;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef PATH_RLE_EN
  maze_rle_packer #(
    .MAX_RUN (MAZE_DIM - 1)
  ) u_rle (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_valid (in_valid),
    .move_first (start),
    .move_dir   (in_dir),
    .stream_end (stream_end),
    .rle_valid  (rle_valid),
    .rle_dir    (rle_dir),
    .rle_len    (rle_len)
  );
`else
  // Without the packer the end-of-stream decode has no consumer.
  logic unused_stream_end;
  assign unused_stream_end = stream_end;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maze_path_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_path_checker
// Purpose  : Directed self-checking bench for maze_path_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_path_checker;

  localparam logic [1:0] E = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] W = 2'd2;
  localparam logic [1:0] N = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_dir;
  logic [4:0] pos_row, pos_col;
  logic [8:0] step_count;
  logic       err_bounds, err_reverse, err_overrun;
  logic       done_valid, done_ok;
`ifdef PATH_RLE_EN
  logic       rle_valid;
  logic [1:0] rle_dir;
  logic [4:0] rle_len;
  logic [7:0] rec_q[$];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maze_path_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_dir      (in_dir),
    .pos_row     (pos_row),
    .pos_col     (pos_col),
    .step_count  (step_count),
    .err_bounds  (err_bounds),
    .err_reverse (err_reverse),
    .err_overrun (err_overrun),
    .done_valid  (done_valid),
    .done_ok     (done_ok)
`ifdef PATH_RLE_EN
    ,
    .rle_valid   (rle_valid),
    .rle_dir     (rle_dir),
    .rle_len     (rle_len)
`endif
  );

`ifdef PATH_RLE_EN
  // Record log: {done_valid, dir, len} for every record strobe.
  always @(posedge clk) begin
    #1;
    if (rle_valid) rec_q.push_back({done_valid, rle_dir, rle_len});
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic mv(input logic [1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_dir   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic mvn(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) mv(d);
  endtask

  // Drop in_valid and check the verdict strobe in the following cycle.
  task automatic end_stream(input string tag, input logic exp_ok);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_valid"}, done_valid, 1);
    check({tag, "_done_ok"}, done_ok, exp_ok);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_strobe_1cyc"}, done_valid, 0);
  endtask

  task automatic check_state(input string tag, input int r, input int c, input int n,
                             input logic eb, input logic er, input logic eo);
    check({tag, "_row"}, pos_row, r);
    check({tag, "_col"}, pos_col, c);
    check({tag, "_steps"}, step_count, n);
    check({tag, "_err_bounds"}, err_bounds, eb);
    check({tag, "_err_reverse"}, err_reverse, er);
    check({tag, "_err_overrun"}, err_overrun, eo);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_dir   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1, 1, 0, 0, 0, 0);
    check("reset_done_valid", done_valid, 0);
    check("reset_done_ok", done_ok, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean path to the goal.
`ifdef PATH_RLE_EN
    rec_q.delete();
`endif
    mv(E);
    check_state("first_move", 1, 2, 1, 0, 0, 0);
    mvn(E, 15);
    mvn(S, 16);
    check_state("clean_end", 17, 17, 32, 0, 0, 0);
    check("clean_no_early_done", done_valid, 0);
    end_stream("clean", 1'b1);
    idle_check("clean");
    check_state("clean_hold", 17, 17, 32, 0, 0, 0);
`ifdef PATH_RLE_EN
    check("rle_count", rec_q.size(), 2);
    if (rec_q.size() == 2) begin
      check("rle_rec0", rec_q[0], {1'b0, E, 5'd16});
      check("rle_rec1", rec_q[1], {1'b1, S, 5'd16});
    end
`endif

    // Illegal first move north: position must not move.
    mv(N);
    check_state("bounds_first", 1, 1, 1, 1, 0, 0);
    mvn(E, 16);
    mvn(S, 16);
    check_state("bounds_end", 17, 17, 33, 1, 0, 0);
    end_stream("bounds", 1'b0);
    idle_check("bounds");

    // Immediate reversal.
    mv(E);
    mv(W);
    check_state("reverse", 1, 1, 2, 0, 1, 0);
    end_stream("reverse", 1'b0);
    idle_check("reverse");

    // Short stream that stops short of the goal.
    mvn(E, 4);
    check_state("short", 1, 5, 4, 0, 0, 0);
    end_stream("short", 1'b0);
    idle_check("short");

    // Extra move south while at the goal.
    mvn(E, 16);
    mvn(S, 16);
    mv(S);
    check_state("overrun", 17, 17, 33, 1, 0, 1);
    end_stream("overrun", 1'b0);

    // New stream starting in the verdict cycle clears history.
    mv(S);
    check_state("restart", 2, 1, 1, 0, 0, 0);
    check("restart_strobe_off", done_valid, 0);
    end_stream("restart", 1'b0);
    idle_check("restart");

    // Step counter saturation (alternating E/W).
    for (int i = 0; i < 260; i++) begin
      mv(E);
      mv(W);
    end
    check_state("saturate", 1, 1, 511, 0, 1, 0);
    end_stream("saturate", 1'b0);
    idle_check("saturate");

    // Asynchronous reset mid-stream.
    mvn(E, 10);
    check_state("pre_reset", 1, 11, 10, 0, 0, 0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_state("async_reset", 1, 1, 0, 0, 0, 0);
    check("async_reset_done_valid", done_valid, 0);
    @(posedge clk);
    #1;
    check("reset_hold_done_valid", done_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("post_reset_done_valid", done_valid, 0);
    end
    check_state("post_reset", 1, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
